gcd_engine: RTL and testbench

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_datapath.sv | 65 ++++++
 rtl/gcd_engine.sv | 130 +++++++++++++
 tb/tb_gcd_engine.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg
//   Shared definitions for the subtractive GCD engine.
//   - gcd_state_e : controller state encoding (IDLE / CALC / DONE)
//   - DEF_WIDTH   : default operand/result width
//   - DEF_ITER_W  : default iteration-counter width
package gcd_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ITER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath
//   Operand registers A/B, unsigned comparator and subtractor for the
//   subtractive GCD algorithm. The controller decides when to load and
//   when to step; this block only moves data.
//
// Ports
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset, clears A and B
//   load  in   capture a_in/b_in into A/B
//   step  in   subtract the smaller register from the larger one
//   a_in  in   operand A
//   b_in  in   operand B
//   a     out  current A register
//   b     out  current B register
//   lt    out  A <  B (unsigned)
//   gt    out  A >  B (unsigned)
//   eq    out  A == B
//   zero  out  A == 0 or B == 0
module gcd_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             zero
);

  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;

  // Both differences are formed, but only the one whose minuend is the
  // larger register is ever written back, so neither can underflow.
  assign a_minus_b = a - b;
  assign b_minus_a = b - a;

  assign lt   = (a < b);
  assign gt   = (a > b);
  assign eq   = (a == b);
  assign zero = (a == '0) || (b == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
    end else if (load) begin
      a <= a_in;
      b <= b_in;
    end else if (step) begin
      if (lt) begin
        b <= b_minus_a;
      end else if (gt) begin
        a <= a_minus_b;
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine
//   Request/acknowledge GCD calculator using repeated subtraction.
//   A request is accepted while ready=1 by pulsing start; the engine then
//   iterates until the operands match (or one is zero) and raises done
//   for one cycle with result, iter and zero_op valid. Those three stay
//   held until the next accepted request.
//
//   Handshake: start is only looked at while ready=1 (IDLE). A start seen
//   in IDLE is consumed on that edge; start in any other state is dropped,
//   never queued. done is a single-cycle pulse and is not back-pressured.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   request strobe
//   a_in      in   operand A (unsigned), sampled with start
//   b_in      in   operand B (unsigned), sampled with start
//   ready     out  high only in IDLE
//   done      out  one-cycle result-valid pulse
//   result    out  gcd(A,B)
//   iter      out  number of subtraction steps, saturating
//   zero_op   out  an operand was zero
//   fsm_state out  controller state, for observation only
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ITER_W = DEF_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              ready,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [ITER_W-1:0] iter,
  output logic              zero_op,
  output gcd_state_e        fsm_state
);

  gcd_state_e       state;
  logic             dp_load;
  logic             dp_step;
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic             dp_lt;
  logic             dp_gt;
  logic             dp_eq;
  logic             dp_zero;

  assign fsm_state = state;

  // Datapath controls. These only feed registers inside the datapath, so
  // start/a_in/b_in never reach an output combinationally.
  assign dp_load = (state == ST_IDLE) && start;
  assign dp_step = (state == ST_CALC) && !dp_zero && !dp_eq;

  gcd_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk  (clk),
    .rst  (rst),
    .load (dp_load),
    .step (dp_step),
    .a_in (a_in),
    .b_in (b_in),
    .a    (dp_a),
    .b    (dp_b),
    .lt   (dp_lt),
    .gt   (dp_gt),
    .eq   (dp_eq),
    .zero (dp_zero)
  );

  // Controller. ready and done are registered alongside the state so they
  // reflect the state being entered: ready=1 exactly while in IDLE and
  // done=1 exactly while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      result  <= '0;
      iter    <= '0;
      zero_op <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            iter    <= '0;
            zero_op <= 1'b0;
            ready   <= 1'b0;
            state   <= ST_CALC;
          end
        end

        ST_CALC: begin
          if (dp_zero) begin
            // gcd(x,0) = x and gcd(0,0) = 0; OR picks the nonzero one.
            result  <= dp_a | dp_b;
            zero_op <= 1'b1;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else if (dp_eq) begin
            result <= dp_a;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else if (iter != '1) begin
            // Saturate: the datapath keeps stepping, only the count stops.
            iter <= iter + ITER_W'(1);
          end
        end

        ST_DONE: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end

        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine
//   Directed and random checks of gcd_engine. Two instances share the clock
//   and reset: inst 0 uses the default widths, inst 1 has ITER_W=4 so the
//   iteration counter saturates. Expected values come from a Euclid
//   (division based) reference model.
module tb_gcd_engine;
  import gcd_pkg::*;

  logic        clk;
  logic        rst;
  logic        start_v [2];
  logic [7:0]  a_v     [2];
  logic [7:0]  b_v     [2];
  logic        ready_v [2];
  logic        done_v  [2];
  logic [7:0]  res_v   [2];
  logic        zop_v   [2];
  gcd_state_e  st_v    [2];
  logic [15:0] iter0;
  logic [3:0]  iter1;

  int n_checks;
  int n_fail;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(8), .ITER_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start_v[0]),
    .a_in      (a_v[0]),
    .b_in      (b_v[0]),
    .ready     (ready_v[0]),
    .done      (done_v[0]),
    .result    (res_v[0]),
    .iter      (iter0),
    .zero_op   (zop_v[0]),
    .fsm_state (st_v[0])
  );

  gcd_engine #(.WIDTH(8), .ITER_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .start     (start_v[1]),
    .a_in      (a_v[1]),
    .b_in      (b_v[1]),
    .ready     (ready_v[1]),
    .done      (done_v[1]),
    .result    (res_v[1]),
    .iter      (iter1),
    .zero_op   (zop_v[1]),
    .fsm_state (st_v[1])
  );

  // ---------------- reference model ----------------
  function automatic int ref_gcd(input int a, input int b);
    int x, y, r;
    x = a;
    y = b;
    while (y != 0) begin
      r = x % y;
      x = y;
      y = r;
    end
    return x;
  endfunction

  // Subtraction steps = sum of Euclid quotients, minus one for the final
  // division (the loop stops when the operands become equal).
  function automatic int ref_steps(input int a, input int b);
    int x, y, q, r, n;
    if (a == 0 || b == 0) return 0;
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    n = 0;
    forever begin
      q = x / y;
      r = x % y;
      if (r == 0) begin
        n = n + q - 1;
        break;
      end
      n = n + q;
      x = y;
      y = r;
    end
    return n;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] iter_of(input int s);
    return (s == 0) ? iter0 : {12'd0, iter1};
  endfunction

  // ---------------- driver ----------------
  // Issues one request on instance s and checks the full response.
  // noise=1 pulses a competing start (9,6) during CALC, which must be ignored.
  task automatic run_op(input int s, input logic [7:0] a, input logic [7:0] b, input bit noise);
    int steps, exp_iter, cnt, sat_max;
    bit seen;
    logic [7:0] exp_res;
    sat_max  = (s == 0) ? 65535 : 15;
    steps    = ref_steps(a, b);
    exp_iter = (steps > sat_max) ? sat_max : steps;
    exp_q.push_back(8'(ref_gcd(a, b)));

    @(negedge clk);
    check("ready_before_start", 32'(ready_v[s]), 32'd1);
    start_v[s] = 1'b1;
    a_v[s]     = a;
    b_v[s]     = b;
    @(posedge clk);
    #1;
    start_v[s] = 1'b0;
    a_v[s]     = 8'($urandom_range(0, 255));
    b_v[s]     = 8'($urandom_range(0, 255));
    cnt  = 1;
    seen = 1'b0;
    while (cnt < 400) begin
      if (done_v[s]) begin
        seen = 1'b1;
        break;
      end
      if (noise && cnt <= 2) begin
        start_v[s] = 1'b1;
        a_v[s]     = 8'd9;
        b_v[s]     = 8'd6;
      end else begin
        start_v[s] = 1'b0;
      end
      @(posedge clk);
      #1;
      cnt++;
    end
    start_v[s] = 1'b0;

    check("done_seen", 32'(seen), 32'd1);
    exp_res = exp_q.pop_front();
    if (seen) begin
      check("latency_edges", 32'(cnt), 32'(steps + 2));
      check("result", 32'(res_v[s]), 32'(exp_res));
      check("iter", 32'(iter_of(s)), 32'(exp_iter));
      check("zero_op", 32'(zop_v[s]), 32'((a == 0) || (b == 0)));
      check("ready_in_done", 32'(ready_v[s]), 32'd0);
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done_v[s]), 32'd0);
      check("ready_after_done", 32'(ready_v[s]), 32'd1);
      check("result_held", 32'(res_v[s]), 32'(exp_res));
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    int extra_done;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      a_v[i]     = 8'd0;
      b_v[i]     = 8'd0;
    end

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 32'(ready_v[0]), 32'd1);
    check("rst_done", 32'(done_v[0]), 32'd0);
    check("rst_result", 32'(res_v[0]), 32'd0);
    check("rst_iter", 32'(iter0), 32'd0);
    check("rst_zero_op", 32'(zop_v[0]), 32'd0);

    // Directed cases
    run_op(0, 8'd12, 8'd18, 1'b0);
    run_op(0, 8'd7,  8'd7,  1'b0);
    run_op(0, 8'd0,  8'd0,  1'b0);
    run_op(0, 8'd0,  8'd45, 1'b0);
    run_op(0, 8'd45, 8'd0,  1'b0);
    run_op(0, 8'd1,  8'd255, 1'b0);
    run_op(1, 8'd1,  8'd255, 1'b0);
    run_op(1, 8'd12, 8'd18, 1'b0);

    // Competing start during CALC is dropped; exactly one done follows
    run_op(0, 8'd12, 8'd18, 1'b1);
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) extra_done++;
    end
    check("no_extra_done", 32'(extra_done), 32'd0);
    check("ready_after_noise", 32'(ready_v[0]), 32'd1);
    check("result_after_noise", 32'(res_v[0]), 32'd6);

    // Reset aborts an in-progress CALC
    @(negedge clk);
    start_v[0] = 1'b1;
    a_v[0]     = 8'd1;
    b_v[0]     = 8'd200;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready", 32'(ready_v[0]), 32'd1);
    check("abort_done", 32'(done_v[0]), 32'd0);
    check("abort_result", 32'(res_v[0]), 32'd0);
    check("abort_iter", 32'(iter0), 32'd0);
    check("abort_zero_op", 32'(zop_v[0]), 32'd0);
    extra_done = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) extra_done++;
    end
    check("abort_no_done", 32'(extra_done), 32'd0);
    run_op(0, 8'd8, 8'd12, 1'b0);

    // Random stimulus, back to back
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0)
        run_op(0, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0);
      else
        run_op(0, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      run_op(1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
